// File: rtl/mem_load_run_dump.sv
// Loads a byte stream into memory, hands memory to a processor for one run,
// then reads back and transmits the first DUMP_WORDS words LSB-first.
//   state | meaning
//   IDLE  | waiting for go
//   LOAD  | assembling rx bytes into words and writing them
//   RUN   | processor owns memory until cpu_done or timeout
//   RD    | read strobe, then capture of the read word
//   TX    | transmitting the captured word byte by byte
//   DONE  | sequence complete, waiting for go
module mem_load_run_dump #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int LOAD_WORDS = 65536,
    parameter int DUMP_WORDS = 16384,
    parameter int TIMEOUT    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              tx_busy,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_sel,
    output logic              cpu_start,
    input  logic              cpu_done,
    output logic [2:0]        state,
    output logic              done,
    output logic              timeout
);

    localparam int BYTES  = DATA_W / 8;
    localparam int BSEL_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [ADDR_W:0]   LOAD_CNT  = (ADDR_W + 1)'(LOAD_WORDS);
    localparam logic [ADDR_W-1:0] DUMP_LAST = ADDR_W'(DUMP_WORDS - 1);
    localparam logic [BSEL_W-1:0] BYTE_LAST = BSEL_W'(BYTES - 1);
    localparam logic [31:0]       RUN_LOAD  = 32'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_RUN  = 3'd2,
        S_RD   = 3'd3,
        S_TX   = 3'd4,
        S_DONE = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        TX_WAIT_IDLE = 2'd0,
        TX_WAIT_RISE = 2'd1,
        TX_WAIT_FALL = 2'd2
    } tx_ph_t;

    state_t              r_state;
    tx_ph_t              r_tx_ph;
    logic [ADDR_W-1:0]   r_load_addr;
    logic [ADDR_W:0]     r_load_cnt;
    logic [ADDR_W-1:0]   r_dump_idx;
    logic [BSEL_W-1:0]   r_byte_idx;
    logic [BSEL_W-1:0]   r_byte_sel;
    logic [DATA_W-1:0]   r_part;
    logic [DATA_W-1:0]   r_cap;
    logic [31:0]         r_run_cnt;
    logic                r_mem_we;
    logic                r_mem_re;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic                r_tx_start;
    logic [7:0]          r_tx_data;
    logic                r_timeout;

    state_t              w_next_state;
    logic                w_rx_accept;
    logic                w_timeout_hit;
    logic                w_tx_fire;
    logic                w_tx_byte_end;
    logic                w_load_full;
    logic [DATA_W-1:0]   w_word;

    assign w_load_full = (r_load_cnt == LOAD_CNT);

    always_comb begin
        w_word = r_part;
        w_word[{r_byte_idx, 3'b000} +: 8] = rx_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state  = r_state;
        w_rx_accept   = 1'b0;
        w_timeout_hit = 1'b0;
        w_tx_fire     = 1'b0;
        w_tx_byte_end = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: if (go) w_next_state = S_LOAD;
            S_LOAD: begin
                // the last word's write cycle is still LOAD; RUN follows it
                if (w_load_full) w_next_state = S_RUN;
                else             w_rx_accept  = rx_valid;
            end
            S_RUN: begin
                if (cpu_done) begin
                    w_next_state = S_RD;
                end else if ((TIMEOUT > 0) && (r_run_cnt == 32'd0)) begin
                    w_next_state  = S_RD;
                    w_timeout_hit = 1'b1;
                end
            end
            S_RD: if (!r_mem_re) w_next_state = S_TX;
            S_TX: begin
                case (r_tx_ph)
                    TX_WAIT_IDLE: w_tx_fire = !tx_busy;
                    TX_WAIT_FALL: begin
                        if (!tx_busy) begin
                            w_tx_byte_end = 1'b1;
                            if (r_byte_sel == BYTE_LAST)
                                w_next_state = (r_dump_idx == DUMP_LAST) ? S_DONE : S_RD;
                        end
                    end
                    default: ;
                endcase
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_ph     <= TX_WAIT_IDLE;
            r_load_addr <= '0;
            r_load_cnt  <= '0;
            r_dump_idx  <= '0;
            r_byte_idx  <= '0;
            r_byte_sel  <= '0;
            r_part      <= '0;
            r_cap       <= '0;
            r_run_cnt   <= '0;
            r_mem_we    <= 1'b0;
            r_mem_re    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_tx_start  <= 1'b0;
            r_tx_data   <= '0;
            r_timeout   <= 1'b0;
        end else begin
            r_mem_we   <= 1'b0;
            r_mem_re   <= 1'b0;
            r_tx_start <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (go) begin
                        r_load_addr <= '0;
                        r_load_cnt  <= '0;
                        r_part      <= '0;
                        r_byte_idx  <= '0;
                        r_timeout   <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (w_rx_accept) begin
                        if (r_byte_idx == BYTE_LAST) begin
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= r_load_addr;
                            r_mem_wdata <= w_word;
                            r_load_addr <= r_load_addr + ADDR_W'(1);
                            r_load_cnt  <= r_load_cnt + (ADDR_W + 1)'(1);
                            r_byte_idx  <= '0;
                            r_part      <= '0;
                        end else begin
                            r_part      <= w_word;
                            r_byte_idx  <= r_byte_idx + BSEL_W'(1);
                        end
                    end
                    if (w_load_full) r_run_cnt <= RUN_LOAD;
                end
                S_RUN: begin
                    if (r_run_cnt != 32'd0) r_run_cnt <= r_run_cnt - 32'd1;
                    if (w_next_state == S_RD) begin
                        r_dump_idx <= '0;
                        r_mem_addr <= '0;
                        r_mem_re   <= 1'b1;
                        r_timeout  <= w_timeout_hit;
                    end
                end
                S_RD: begin
                    if (!r_mem_re) begin
                        r_cap      <= mem_rdata;
                        r_byte_sel <= '0;
                        r_tx_ph    <= TX_WAIT_IDLE;
                    end
                end
                S_TX: begin
                    case (r_tx_ph)
                        TX_WAIT_IDLE: begin
                            if (w_tx_fire) begin
                                r_tx_start <= 1'b1;
                                r_tx_data  <= r_cap[{r_byte_sel, 3'b000} +: 8];
                                r_tx_ph    <= TX_WAIT_RISE;
                            end
                        end
                        TX_WAIT_RISE: if (tx_busy) r_tx_ph <= TX_WAIT_FALL;
                        TX_WAIT_FALL: begin
                            if (w_tx_byte_end) begin
                                r_tx_ph    <= TX_WAIT_IDLE;
                                r_byte_sel <= r_byte_sel + BSEL_W'(1);
                                if (w_next_state == S_RD) begin
                                    r_dump_idx <= r_dump_idx + ADDR_W'(1);
                                    r_mem_addr <= r_dump_idx + ADDR_W'(1);
                                    r_mem_re   <= 1'b1;
                                end
                            end
                        end
                        default: r_tx_ph <= TX_WAIT_IDLE;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign state     = r_state;
    assign done      = (r_state == S_DONE);
    assign mem_sel   = (r_state == S_RUN);
    assign cpu_start = (r_state == S_RUN);
    assign timeout   = r_timeout;
    assign mem_we    = r_mem_we;
    assign mem_re    = r_mem_re;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign tx_start  = r_tx_start;
    assign tx_data   = r_tx_data;

endmodule

// File: tb/tb_mem_load_run_dump.sv
// Directed bench: memory and transmitter models, with write and tx scoreboards
// checked whenever the DUT strobes.
module tb_mem_load_run_dump;

    localparam int ADDR_W     = 16;
    localparam int DATA_W     = 16;
    localparam int LOAD_WORDS = 4;
    localparam int DUMP_WORDS = 2;
    localparam int TIMEOUT    = 20;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              go = 1'b0;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              tx_busy;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              mem_sel;
    logic              cpu_start;
    logic              cpu_done = 1'b0;
    logic [2:0]        state;
    logic              done;
    logic              timeout;

    mem_load_run_dump #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOAD_WORDS(LOAD_WORDS),
        .DUMP_WORDS(DUMP_WORDS), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .go(go), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata), .mem_sel(mem_sel), .cpu_start(cpu_start),
        .cpu_done(cpu_done), .state(state), .done(done), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [31:0] wq[$];
    logic [7:0]  tq[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // memory: read data valid the cycle after mem_re
    logic [15:0] mem [16];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[3:0]] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr[3:0]];
    end

    // transmitter: busy for 4 cycles after each accepted tx_start
    logic model_busy = 1'b0;
    logic ext_busy = 1'b0;
    int   busy_cnt = 0;
    assign tx_busy = model_busy | ext_busy;
    always @(posedge clk) begin
        if (rst) begin
            model_busy <= 1'b0;
        end else if (tx_start) begin
            model_busy <= 1'b1;
            busy_cnt   <= 3;
        end else if (model_busy) begin
            if (busy_cnt == 0) model_busy <= 1'b0;
            else               busy_cnt   <= busy_cnt - 1;
        end
    end

    logic        prev_we = 1'b0;
    logic        prev_ts = 1'b0;
    logic [2:0]  prev_state = 3'd0;
    int          run_cur = 0;
    int          run_len = 0;
    logic [31:0] mon_e;
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_we) begin
                chk("we_expected", 64'(wq.size() != 0), 64'd1);
                if (wq.size() != 0) begin
                    mon_e = wq.pop_front();
                    chk("we_addr", 64'(mem_addr), 64'(mon_e[31:16]));
                    chk("we_data", 64'(mem_wdata), 64'(mon_e[15:0]));
                end
                chk("we_state", 64'(state), 64'd1);
                chk("we_pulse", 64'(prev_we), 64'd0);
            end
            if (tx_start) begin
                chk("ts_busy", 64'(tx_busy), 64'd0);
                chk("ts_pulse", 64'(prev_ts), 64'd0);
                chk("tx_expected", 64'(tq.size() != 0), 64'd1);
                if (tq.size() != 0) chk("tx_data", 64'(tx_data), 64'(tq.pop_front()));
            end
            if (state == 3'd2) begin
                run_cur++;
            end else if (prev_state == 3'd2) begin
                run_len = run_cur;
                run_cur = 0;
            end
        end
        prev_we    = mem_we;
        prev_ts    = tx_start;
        prev_state = state;
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic load_word(input logic [15:0] a, input logic [15:0] d);
        wq.push_back({a, d});
        send_byte(d[7:0]);
        send_byte(d[15:8]);
        chk("load_we", 64'(mem_we), 64'd1);
    endtask

    task automatic go_pulse();
        @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] s, input int max, input string tag);
        for (int i = 0; i < max && state !== s; i++) @(negedge clk);
        chk(tag, 64'(state), 64'(s));
    endtask

    task automatic push_tx(input logic [15:0] w0, input logic [15:0] w1);
        tq.push_back(w0[7:0]);
        tq.push_back(w0[15:8]);
        tq.push_back(w1[7:0]);
        tq.push_back(w1[15:8]);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [15:0] wa[4];
    logic [15:0] wb[4];
    logic [15:0] wc[4];
    logic [15:0] wd[4];

    initial begin
        wa = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
        wb = '{16'hA1B2, 16'hC3D4, 16'hE5F6, 16'h0718};
        wc = '{16'h0F1E, 16'h2D3C, 16'h4B5A, 16'h6978};
        wd = '{16'hCAFE, 16'hBEEF, 16'h0102, 16'h0304};

        repeat (2) @(negedge clk);
        chk("rst_outputs", 64'({tx_start, tx_data, mem_addr, mem_wdata, mem_we, mem_re,
                                mem_sel, cpu_start, state, done, timeout}), 64'd0);
        rst = 1'b0;
        send_byte(8'hAA);
        chk("idle_rx_ignored", 64'({state, mem_we}), 64'd0);

        // load and dump with cpu_done after 5 RUN cycles
        go_pulse();
        chk("go_load", 64'(state), 64'd1);
        for (int i = 0; i < 4; i++) load_word(16'(i), wa[i]);
        chk("last_write_in_load", 64'(state), 64'd1);
        @(negedge clk);
        chk("run_entry", 64'({state, cpu_start, mem_sel, mem_we}), 64'({3'd2, 1'b1, 1'b1, 1'b0}));
        chk("writes_done", 64'(wq.size()), 64'd0);
        repeat (3) @(negedge clk);
        ext_busy = 1'b1;
        @(negedge clk);
        cpu_done = 1'b1;
        @(negedge clk);
        cpu_done = 1'b0;
        chk("rd_entry", 64'({state, mem_re, mem_addr, cpu_start, mem_sel, timeout}),
            64'({3'd3, 1'b1, 16'd0, 1'b0, 1'b0, 1'b0}));
        push_tx(wa[0], wa[1]);
        repeat (6) @(negedge clk);
        chk("tx_held_busy", 64'(tq.size()), 64'd4);
        ext_busy = 1'b0;
        wait_state(3'd5, 300, "dump_a_done");
        chk("done_a_flags", 64'({done, timeout}), 64'b10);
        chk("run_len_a", 64'(run_len), 64'd5);
        chk("tx_a_all_sent", 64'(tq.size()), 64'd0);
        repeat (3) @(negedge clk);
        chk("done_hold", 64'({state, done}), 64'({3'd5, 1'b1}));

        // timeout; go during RUN and rx during TX ignored
        go_pulse();
        chk("go_from_done", 64'({state, done, timeout}), 64'({3'd1, 1'b0, 1'b0}));
        for (int i = 0; i < 4; i++) load_word(16'(i), wb[i]);
        @(negedge clk);
        chk("run_b_entry", 64'(state), 64'd2);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        chk("go_ignored_run", 64'(state), 64'd2);
        push_tx(wb[0], wb[1]);
        wait_state(3'd4, 100, "tx_b_entry");
        chk("timeout_b_flag", 64'(timeout), 64'd1);
        for (int i = 0; i < 20 && tx_start !== 1'b1; i++) @(negedge clk);
        chk("tx_b_fire", 64'(tx_start), 64'd1);
        rx_valid = 1'b1;
        rx_data  = 8'h55;
        @(negedge clk);
        rx_valid = 1'b0;
        chk("rx_ignored_tx", 64'({state, mem_we}), 64'({3'd4, 1'b0}));
        wait_state(3'd5, 300, "dump_b_done");
        chk("done_b_flags", 64'({done, timeout}), 64'b11);
        chk("run_len_b", 64'(run_len), 64'd20);
        chk("tx_b_all_sent", 64'(tq.size()), 64'd0);

        // cpu_done on the 20th RUN cycle beats the timeout
        go_pulse();
        chk("go_clears_timeout", 64'({state, done, timeout}), 64'({3'd1, 1'b0, 1'b0}));
        for (int i = 0; i < 4; i++) load_word(16'(i), wc[i]);
        @(negedge clk);
        chk("run_c_entry", 64'(state), 64'd2);
        repeat (19) @(negedge clk);
        cpu_done = 1'b1;
        @(negedge clk);
        cpu_done = 1'b0;
        chk("tie_rd", 64'({state, timeout}), 64'({3'd3, 1'b0}));
        push_tx(wc[0], wc[1]);
        wait_state(3'd5, 300, "dump_c_done");
        chk("done_c_timeout", 64'(timeout), 64'd0);
        chk("run_len_c", 64'(run_len), 64'd20);

        // reset after 3 bytes, then a clean reload from address 0
        go_pulse();
        load_word(16'd0, 16'h1111);
        send_byte(8'h22);
        rst = 1'b1;
        #1;
        chk("rst_mid_outputs", 64'({tx_start, tx_data, mem_addr, mem_wdata, mem_we, mem_re,
                                    mem_sel, cpu_start, state, done, timeout}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_idle", 64'({state, mem_we, mem_re, tx_start}), 64'd0);
        go_pulse();
        for (int i = 0; i < 4; i++) load_word(16'(i), wd[i]);
        @(negedge clk);
        chk("run_d_entry", 64'(state), 64'd2);
        cpu_done = 1'b1;
        @(negedge clk);
        cpu_done = 1'b0;
        push_tx(wd[0], wd[1]);
        wait_state(3'd5, 300, "dump_d_done");
        chk("mem0_after_reload", 64'(mem[0]), 64'h0000_0000_0000_CAFE);
        chk("tx_d_all_sent", 64'(tq.size()), 64'd0);
        chk("writes_all_seen", 64'(wq.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_load_run_dump.md
MEM_LOAD_RUN_DUMP -- requirements
Module: mem_load_run_dump

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- ADDR_W, 16, memory address width
- DATA_W, 16, memory word width; a multiple of 8; BYTES = DATA_W/8
- LOAD_WORDS, 65536, words received before the run; 1..2^ADDR_W
- DUMP_WORDS, 16384, words transmitted after the run; 1..2^ADDR_W
- TIMEOUT, 0, maximum RUN cycles; 0 disables the timeout
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  single clock; all logic on its rising edge
- rst  in  1  asynchronous, active-high reset
- go  in  1  start request
- rx_valid  in  1  one-cycle strobe; rx_data holds a received byte
- rx_data  in  8  received byte
- tx_busy  in  1  transmitter busy
- tx_start  out  1  one-cycle transmit request
- tx_data  out  8  byte to transmit
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_we  out  1  memory write strobe
- mem_re  out  1  memory read strobe
- mem_rdata  in  DATA_W  read data, valid 1 cycle after mem_re
- mem_sel  out  1  1 = processor owns memory; the external mux selects on this
- cpu_start  out  1  processor run enable
- cpu_done  in  1  processor end flag
- state  out  3  FSM state code
- done  out  1  sequence complete
- timeout  out  1  RUN ended by timeout

Function
REQ-003 States SHALL be IDLE=0, LOAD=1, RUN=2, RD=3, TX=4, DONE=5.
REQ-004 Transitions:
- IDLE->LOAD on go
- DONE->LOAD on go, clearing done and timeout
- go SHALL be ignored in all other states.
REQ-005 LOAD bytes:
- each rx_valid byte SHALL be assembled LSB-first into a BYTES-byte word
- when the last byte arrives, mem_we SHALL pulse for exactly 1 cycle with mem_addr = word index (0-based) and the full word on mem_wdata
- the word index SHALL then increment.
REQ-006 LOAD exit:
- the cycle after the write of word LOAD_WORDS-1, the block SHALL enter RUN
- mem_sel=1 and cpu_start=1 SHALL hold throughout RUN.
REQ-007 rx_valid outside LOAD SHALL be ignored.
REQ-008 RUN SHALL exit to RD on the first cycle cpu_done=1, with timeout=0.
REQ-009 RUN timeout:
- if TIMEOUT>0, RUN SHALL exit to RD with timeout=1 once the RUN cycle count reaches TIMEOUT
- if cpu_done=1 in that same cycle, cpu_done SHALL win and timeout=0.
REQ-010 Leaving RUN SHALL drop cpu_start and mem_sel in the same cycle and reset the dump index to 0.
REQ-011 RD:
- mem_re SHALL pulse for 1 cycle with mem_addr = dump index
- mem_rdata SHALL be captured the following cycle, then the block SHALL enter TX.
REQ-012 TX:
- bytes SHALL be sent LSB-first
- for each byte: wait for tx_busy=0, pulse tx_start for 1 cycle with tx_data stable, then wait for tx_busy to rise and fall before the next byte.
REQ-013 TX exit:
- after BYTES bytes, if the dump index = DUMP_WORDS-1 the block SHALL enter DONE
- otherwise it SHALL increment the index and return to RD.
REQ-014 DONE SHALL hold done=1 until go or rst.
REQ-015 Wrap-around: address counters SHALL be ADDR_W bits wide; LOAD_WORDS = 2^ADDR_W SHALL terminate via a separate ADDR_W+1-bit count, not address wrap.
REQ-016 Idle strobes: mem_we, mem_re and tx_start SHALL be 0 in every cycle not stated above.
REQ-017 Simultaneous events: an rx_valid that completes the last word SHALL write in that cycle; the transition to RUN follows on the next cycle with no lost write.

Reset
REQ-018 rst=1 SHALL, asynchronously, set:
- state=IDLE
- all counters, the partial word and the capture register to 0
- tx_start, mem_we, mem_re, mem_sel, cpu_start, done, timeout = 0
- tx_data, mem_addr, mem_wdata = 0
REQ-019 rst asserted mid-LOAD/RUN/TX SHALL abort the sequence and discard the partial word; no further strobes SHALL occur until a new go.

Verification
(Parameters: DATA_W=16, LOAD_WORDS=4, DUMP_WORDS=2, TIMEOUT=20.)
REQ-020 Load: go, then bytes 34,12,78,56,BC,9A,F0,DE -> writes 0x1234@0, 0x5678@1, 0x9ABC@2, 0xDEF0@3, each mem_we 1 cycle; RUN entered the next cycle with cpu_start=1, mem_sel=1.
REQ-021 Dump: cpu_done after 5 RUN cycles, memory holds 0x1234@0 and 0x5678@1 -> tx_start sequence 34,12,78,56; each tx_start only after tx_busy=0; then done=1, timeout=0, state=5.
REQ-022 Timeout: cpu_done never asserted -> exactly 20 RUN cycles, then timeout=1 and the dump proceeds.
REQ-023 Tie: cpu_done rises on the 20th RUN cycle -> timeout=0.
REQ-024 Reset mid-operation: rst after 3 bytes -> all outputs 0, state=0; a new go plus 8 bytes writes address 0 first.
REQ-025 Ignored inputs: go during RUN and rx_valid during TX -> no state change, no mem_we.
